ram2p_clr: RTL



---
 rtl/ram2p_clr_pkg.sv | 17 +
 rtl/ram2p_clr_if.sv | 30 +++
 rtl/ram2p_clr_seq.sv | 98 +++++++++
 rtl/ram2p_clr.sv | 91 +++++++++
 4 files changed

// File: rtl/ram2p_clr_pkg.sv
// Shared types and constants for the two-port RAM with its clear sweep.
package ram2p_clr_pkg;

    // The sweep state comes first so that the reset value reads naturally.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ADDR_W = 7;

    // Read-port modes for the READ_REG parameter.
    localparam int unsigned READ_ASYNC = 0;
    localparam int unsigned READ_SYNC  = 1;

endpackage

// File: rtl/ram2p_clr_if.sv
// Bus bundle for ram2p_clr: write port, read port, clear request and status.
interface ram2p_clr_if
    import ram2p_clr_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
);

    logic [DATA_W-1:0] dataIn;
    logic [ADDR_W-1:0] adr_a;
    logic              we;        // active-low write enable
    logic [ADDR_W-1:0] adr_b;
    logic              clr;
    logic [DATA_W-1:0] dataOut;
    logic              busy;
    logic              wr_drop;

    // Client side of the RAM.
    modport master (
        output dataIn, adr_a, we, adr_b, clr,
        input  dataOut, busy, wr_drop
    );

    // RAM side.
    modport slave (
        input  dataIn, adr_a, we, adr_b, clr,
        output dataOut, busy, wr_drop
    );

endinterface

// File: rtl/ram2p_clr_seq.sv
// Clear sequencer: sweep FSM, address counter, status flags and the write-port mux
// that chooses between the sweep and user writes.
module ram2p_clr_seq
    import ram2p_clr_pkg::*;
#(
    parameter int unsigned       DATA_W  = DEF_DATA_W,
    parameter int unsigned       ADDR_W  = DEF_ADDR_W,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              wr_n_i,
    input  logic              clr_i,
    input  logic [ADDR_W-1:0] adr_i,
    input  logic [DATA_W-1:0] dat_i,
    output logic              busy_o,
    output logic              sweep_next_o,
    output logic              wr_drop_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_adr_o,
    output logic [DATA_W-1:0] mem_dat_o
);

    // One extra bit so the terminal compare never depends on wrap-around.
    localparam logic [ADDR_W:0] CNT_LAST = {1'b0, {ADDR_W{1'b1}}};

    state_t          state_q;
    logic [ADDR_W:0] cnt_q;
    logic [ADDR_W:0] cnt_d;
    logic            busy_q;
    logic            wr_drop_q;

    // Counter increment used by the sweep.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
    end

    // Sweep FSM with registered busy and dropped-write flags.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            wr_drop_q <= 1'b0;
        end else begin
            wr_drop_q <= 1'b0;
            unique case (state_q)
                ST_CLEAR: begin
                    cnt_q     <= cnt_d;
                    wr_drop_q <= ~wr_n_i;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (clr_i) begin
                        state_q <= ST_CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    // Whether the cycle after the coming edge is still part of a sweep; the
    // registered read path uses it to keep CLR_VAL on dataOut.
    always_comb begin
        sweep_next_o = 1'b0;
        if (state_q == ST_CLEAR) begin
            sweep_next_o = (cnt_q != CNT_LAST);
        end else begin
            sweep_next_o = clr_i;
        end
    end

    // Write-port mux: the sweep owns the array while clearing.
    always_comb begin
        mem_we_o  = ~wr_n_i;
        mem_adr_o = adr_i;
        mem_dat_o = dat_i;
        if (state_q == ST_CLEAR) begin
            mem_we_o  = 1'b1;
            mem_adr_o = cnt_q[ADDR_W-1:0];
            mem_dat_o = CLR_VAL;
        end
    end

    assign busy_o    = busy_q;
    assign wr_drop_o = wr_drop_q;

endmodule

// File: rtl/ram2p_clr.sv
// Two-port RAM (write port A, read port B) with selectable async/registered read,
// optional write-to-read bypass and a built-in clear sweep.
module ram2p_clr
    import ram2p_clr_pkg::*;
#(
    parameter int unsigned       DATA_W   = DEF_DATA_W,
    parameter int unsigned       ADDR_W   = DEF_ADDR_W,
    parameter int unsigned       READ_REG = READ_ASYNC,
    parameter int unsigned       BYPASS   = 1,
    parameter logic [DATA_W-1:0] CLR_VAL  = '0
) (
    input logic       ck,
    input logic       rst,
    ram2p_clr_if.slave bus
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              busy;
    logic              sweep_next;
    logic              wr_drop;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_dat;

    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] rd_d;
    logic [DATA_W-1:0] dout;

    ram2p_clr_seq #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .CLR_VAL (CLR_VAL)
    ) u_seq (
        .ck           (ck),
        .rst          (rst),
        .wr_n_i       (bus.we),
        .clr_i        (bus.clr),
        .adr_i        (bus.adr_a),
        .dat_i        (bus.dataIn),
        .busy_o       (busy),
        .sweep_next_o (sweep_next),
        .wr_drop_o    (wr_drop),
        .mem_we_o     (mem_we),
        .mem_adr_o    (mem_adr),
        .mem_dat_o    (mem_dat)
    );

    // Storage array; contents are only initialised by the sweep, never by rst.
    always_ff @(posedge ck) begin
        if (mem_we) begin
            mem[mem_adr] <= mem_dat;
        end
    end

    // Next registered read value: fill value while sweeping, optional
    // same-address forwarding, otherwise the pre-edge array contents.
    always_comb begin
        rd_d = mem[bus.adr_b];
        if (sweep_next) begin
            rd_d = CLR_VAL;
        end else if ((BYPASS != 0) && mem_we && (mem_adr == bus.adr_b)) begin
            rd_d = mem_dat;
        end
    end

    // Registered read data, cleared by reset.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    // Output select between registered and combinational read.
    always_comb begin
        if (READ_REG == READ_SYNC) begin
            dout = rd_q;
        end else begin
            dout = busy ? CLR_VAL : mem[bus.adr_b];
        end
    end

    assign bus.dataOut = dout;
    assign bus.busy    = busy;
    assign bus.wr_drop = wr_drop;

endmodule
